// File: rtl/alu_cmd_sequencer.sv
// Command issue stage for the 8-bit ALU. It queues requests in a small FIFO,
// powers the ALU up, drives one command at a time, and returns one tagged
// result per command.
module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [1:0] cmd_mode,
  output logic       alu_on,
  output logic [2:0] alu_in_sel,
  output logic [7:0] alu_num1,
  output logic [7:0] alu_num2,
  output logic [6:0] alu_out_sel,
  input  logic [7:0] alu_out,
  input  logic [1:0] alu_state,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic       res_err,
  output logic       res_timeout,
  output logic       busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] SEL_RST  = 3'b100;
  localparam logic [2:0] SEL_LOAD = 3'b010;
  localparam logic [2:0] SEL_HOLD = 3'b001;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] mode;
  } cmd_t;

  typedef enum logic [2:0] {
    S_PWRUP, S_IDLE, S_ISSUE, S_WAIT, S_RESP
  } state_t;

  state_t         state_q, state_d;
  cmd_t           fifo_q [DEPTH];
  cmd_t           head;
  logic [AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           cmd_ready_q, cmd_ready_d;
  logic           busy_q, busy_d;
  logic           push, pop;
  logic [TW-1:0]  timer_q, timer_d;
  logic           off_q, off_d;   // ALU dropped to Off during WAIT
  logic           alu_on_q, alu_on_d;
  logic [2:0]     in_sel_q, in_sel_d;
  logic [7:0]     num1_q, num1_d, num2_q, num2_d;
  logic [6:0]     out_sel_q, out_sel_d;
  logic           res_valid_q, res_valid_d;
  logic [7:0]     res_data_q, res_data_d;
  logic           res_err_q, res_err_d;
  logic           res_to_q, res_to_d;

  assign push = cmd_valid & cmd_ready_q;
  assign head = fifo_q[rptr_q];

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= '{op: cmd_op, a: cmd_a, b: cmd_b, mode: cmd_mode};
  end

  // FIFO pointer/count update; power-of-2 depth lets pointers wrap naturally
  always_comb begin
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    cmd_ready_d = (count_d != CW'(DEPTH));
  end

  // Next-state and registered-output logic of the issue FSM
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    timer_d     = timer_q;
    off_d       = off_q;
    alu_on_d    = alu_on_q;
    in_sel_d    = in_sel_q;
    num1_d      = num1_q;
    num2_d      = num2_q;
    out_sel_d   = out_sel_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    res_to_d    = res_to_q;
    case (state_q)
      S_PWRUP: begin
        alu_on_d = 1'b1;
        in_sel_d = SEL_RST;
        if (alu_state == 2'b01) state_d = S_IDLE;
      end
      S_IDLE: begin
        in_sel_d = SEL_HOLD;
        if (count_q != '0) begin
          pop = 1'b1;
          if (head.op == 3'd7) begin
            // illegal op: answer straight away without touching the ALU
            state_d     = S_RESP;
            res_valid_d = 1'b1;
            res_data_d  = 8'h00;
            res_err_d   = 1'b1;
            res_to_d    = 1'b0;
          end else begin
            num1_d    = head.a;
            num2_d    = head.b;
            out_sel_d = 7'b1 << head.op;
            case (head.mode)
              2'd1:    in_sel_d = SEL_HOLD;
              2'd2:    in_sel_d = SEL_RST;
              default: in_sel_d = SEL_LOAD;
            endcase
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // select pulse lasts this one cycle; operands stay until next pop
        in_sel_d = SEL_HOLD;
        timer_d  = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (alu_state == 2'b10 || alu_state == 2'b11) begin
          state_d     = S_RESP;
          res_valid_d = 1'b1;
          res_data_d  = alu_out;
          res_err_d   = alu_state[0];
          res_to_d    = 1'b0;
        end else if (alu_state == 2'b00) begin
          state_d     = S_RESP;
          off_d       = 1'b1;
          alu_on_d    = 1'b1;
          res_valid_d = 1'b1;
          res_data_d  = 8'h00;
          res_err_d   = 1'b1;
          res_to_d    = 1'b0;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d     = S_RESP;
          res_valid_d = 1'b1;
          res_data_d  = 8'h00;
          res_err_d   = 1'b1;
          res_to_d    = 1'b1;
        end
      end
      S_RESP: begin
        state_d = off_q ? S_PWRUP : S_IDLE;
        off_d   = 1'b0;
      end
      default: state_d = S_PWRUP;
    endcase
    busy_d = (state_d != S_IDLE) || (count_d != '0);
  end

  // All state and outputs registered, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_PWRUP;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      timer_q     <= '0;
      off_q       <= 1'b0;
      alu_on_q    <= 1'b0;
      in_sel_q    <= SEL_RST;
      num1_q      <= '0;
      num2_q      <= '0;
      out_sel_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      res_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      timer_q     <= timer_d;
      off_q       <= off_d;
      alu_on_q    <= alu_on_d;
      in_sel_q    <= in_sel_d;
      num1_q      <= num1_d;
      num2_q      <= num2_d;
      out_sel_q   <= out_sel_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      res_to_q    <= res_to_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign alu_on      = alu_on_q;
  assign alu_in_sel  = in_sel_q;
  assign alu_num1    = num1_q;
  assign alu_num2    = num2_q;
  assign alu_out_sel = out_sel_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_err     = res_err_q;
  assign res_timeout = res_to_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small reactive ALU model.
module tb_alu_cmd_sequencer;
  localparam int TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [7:0] cmd_a = '0, cmd_b = '0;
  logic [1:0] cmd_mode = '0;
  logic       alu_on;
  logic [2:0] alu_in_sel;
  logic [7:0] alu_num1, alu_num2;
  logic [6:0] alu_out_sel;
  logic [7:0] alu_out;
  logic [1:0] alu_state;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_err, res_timeout, busy;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  // model controls
  logic hold_off = 1'b0;
  logic no_run   = 1'b0;

  // monitor records
  logic [7:0] q_data[$];
  logic       q_err[$];
  logic       q_to[$];
  int         q_cyc[$];
  int         load_cnt = 0;
  int         load_cyc = 0;
  logic [6:0] load_outsel = '0;
  int         push_cyc = 0;

  alu_cmd_sequencer #(.DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_mode(cmd_mode),
    .alu_on(alu_on), .alu_in_sel(alu_in_sel), .alu_num1(alu_num1),
    .alu_num2(alu_num2), .alu_out_sel(alu_out_sel), .alu_out(alu_out),
    .alu_state(alu_state), .res_valid(res_valid), .res_data(res_data),
    .res_err(res_err), .res_timeout(res_timeout), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // ALU behaviour: Off until powered, Ready after, runs on a load select
  logic [1:0] m_st;
  logic [7:0] m_out;
  logic [15:0] m_full;
  logic        m_ovf;
  assign alu_state = m_st;
  assign alu_out   = m_out;

  always_comb begin
    m_full = 16'h0;
    m_ovf  = 1'b0;
    case (alu_out_sel)
      7'b0000001: m_full = {8'h0, alu_num1 & alu_num2};
      7'b0000010: m_full = {8'h0, alu_num1 | alu_num2};
      7'b0000100: m_full = {8'h0, alu_num1 ^ alu_num2};
      7'b0001000: m_full = {8'h0, ~alu_num1};
      7'b0010000: m_full = {8'h0, alu_num1} + {8'h0, alu_num2};
      7'b0100000: begin
        m_full = {8'h0, alu_num1 - alu_num2};
        m_ovf  = (alu_num1 < alu_num2);
      end
      7'b1000000: m_full = {8'h0, alu_num1} * {8'h0, alu_num2};
      default:    m_full = 16'h0;
    endcase
    if (m_full > 16'd255) m_ovf = 1'b1;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst)                        m_st <= 2'b00;
    else if (!alu_on || hold_off)    m_st <= 2'b00;
    else if (m_st == 2'b00)          m_st <= 2'b01;
    else if (no_run)                 m_st <= 2'b01;
    else if (alu_in_sel == 3'b100)   m_st <= 2'b01;
    else if (alu_in_sel == 3'b010) begin
      m_st  <= m_ovf ? 2'b11 : 2'b10;
      m_out <= m_full[7:0];
    end
  end

  initial m_out = 8'h00;

  // Output monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (res_valid) begin
      q_data.push_back(res_data);
      q_err.push_back(res_err);
      q_to.push_back(res_timeout);
      q_cyc.push_back(cyc);
    end
    if (rst && alu_in_sel == 3'b010) begin
      load_cnt    = load_cnt + 1;
      load_cyc    = cyc;
      load_outsel = alu_out_sel;
    end
  end

  task automatic clear_mon();
    q_data.delete(); q_err.delete(); q_to.delete(); q_cyc.delete();
    load_cnt = 0;
  endtask

  task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [1:0] mode);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_mode = mode;
    while (cmd_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (cmd_ready !== 1'b1) begin
      compared++; mismatched++;
      $display("FAIL push_accept: cmd_ready=%b required 1", cmd_ready);
    end
    push_cyc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(input int n);
    int k = 0;
    while (q_data.size() < n && k < 300) begin @(posedge clk); k++; end
    if (q_data.size() < n) begin
      compared++; mismatched++;
      $display("FAIL wait_res: got %0d results required %0d", q_data.size(), n);
      while (q_data.size() < n) begin
        q_data.push_back('x); q_err.push_back('x); q_to.push_back('x); q_cyc.push_back(-1000);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    compared++; if (alu_on !== 1'b0) begin mismatched++; $display("FAIL rst_alu_on: got %b required 0", alu_on); end
    compared++; if (alu_in_sel !== 3'b100) begin mismatched++; $display("FAIL rst_in_sel: got %b required 100", alu_in_sel); end
    compared++; if ({alu_num1, alu_num2, alu_out_sel} !== 23'h0) begin mismatched++; $display("FAIL rst_drive: got %h/%h/%b required 0", alu_num1, alu_num2, alu_out_sel); end
    compared++; if ({res_valid, res_data, res_err, res_timeout} !== 11'h0) begin mismatched++; $display("FAIL rst_res: got v=%b d=%h e=%b t=%b required 0", res_valid, res_data, res_err, res_timeout); end
    compared++; if ({cmd_ready, busy} !== 2'b00) begin mismatched++; $display("FAIL rst_ready_busy: got %b%b required 00", cmd_ready, busy); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    compared++; if (cmd_ready !== 1'b1) begin mismatched++; $display("FAIL post_rst_ready: got %b required 1", cmd_ready); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL post_rst_busy: got %b required 1", busy); end
  endtask

  task automatic test_basic();
    clear_mon();
    push(3'd6, 8'd3, 8'd2, 2'd0);
    wait_res(1);
    compared++; if (load_outsel !== 7'b1000000) begin mismatched++; $display("FAIL basic_out_sel: got %b required 1000000", load_outsel); end
    compared++; if (load_cnt !== 1) begin mismatched++; $display("FAIL basic_load_pulse: got %0d cycles required 1", load_cnt); end
    compared++; if (q_data[0] !== 8'd6 || q_err[0] !== 1'b0 || q_to[0] !== 1'b0) begin mismatched++; $display("FAIL basic_result: got d=%0d e=%b t=%b required 6/0/0", q_data[0], q_err[0], q_to[0]); end
    compared++; if (q_cyc[0] - push_cyc < 4) begin mismatched++; $display("FAIL basic_latency: got %0d required >=4", q_cyc[0] - push_cyc); end
    repeat (3) @(negedge clk);
    compared++; if (q_data.size() !== 1 || busy !== 1'b0) begin mismatched++; $display("FAIL basic_single_pulse: got %0d results busy=%b required 1/0", q_data.size(), busy); end
  endtask

  task automatic test_alu_error();
    clear_mon();
    push(3'd6, 8'd87, 8'd26, 2'd0);
    wait_res(1);
    compared++; if (q_data[0] !== 8'd214 || q_err[0] !== 1'b1 || q_to[0] !== 1'b0) begin mismatched++; $display("FAIL alu_err_result: got d=%0d e=%b t=%b required 214/1/0", q_data[0], q_err[0], q_to[0]); end
  endtask

  task automatic test_timeout();
    clear_mon();
    no_run = 1'b1;
    push(3'd4, 8'd1, 8'd1, 2'd0);
    wait_res(1);
    no_run = 1'b0;
    compared++; if (q_cyc[0] - (load_cyc + 1) !== TIMEOUT) begin mismatched++; $display("FAIL timeout_latency: got %0d required %0d", q_cyc[0] - (load_cyc + 1), TIMEOUT); end
    compared++; if (q_data[0] !== 8'd0 || q_err[0] !== 1'b1 || q_to[0] !== 1'b1) begin mismatched++; $display("FAIL timeout_result: got d=%0d e=%b t=%b required 0/1/1", q_data[0], q_err[0], q_to[0]); end
  endtask

  task automatic test_illegal();
    clear_mon();
    push(3'd7, 8'd5, 8'd5, 2'd0);
    wait_res(1);
    compared++; if (q_data[0] !== 8'd0 || q_err[0] !== 1'b1 || q_to[0] !== 1'b0) begin mismatched++; $display("FAIL illegal_result: got d=%0d e=%b t=%b required 0/1/0", q_data[0], q_err[0], q_to[0]); end
    compared++; if (q_cyc[0] - push_cyc > 3) begin mismatched++; $display("FAIL illegal_latency: got %0d required <=3", q_cyc[0] - push_cyc); end
    repeat (3) @(negedge clk);
    compared++; if (load_cnt !== 0 || alu_in_sel !== 3'b001) begin mismatched++; $display("FAIL illegal_no_drive: got loads=%0d in_sel=%b required 0/001", load_cnt, alu_in_sel); end
    compared++; if (res_err !== 1'b1 || res_valid !== 1'b0) begin mismatched++; $display("FAIL illegal_hold: got err=%b valid=%b required 1/0", res_err, res_valid); end
  endtask

  task automatic test_fifo_full();
    logic [2:0] ops [4];
    logic [7:0] as [4], bs [4], ex [4];
    ops = '{3'd0, 3'd1, 3'd2, 3'd4};
    as  = '{8'hF0, 8'hF0, 8'hAA, 8'd100};
    bs  = '{8'h3C, 8'h0F, 8'hFF, 8'd55};
    ex  = '{8'h30, 8'hFF, 8'h55, 8'd155};
    hold_off = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    clear_mon();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      cmd_valid = 1'b1; cmd_op = ops[i]; cmd_a = as[i]; cmd_b = bs[i]; cmd_mode = 2'd0;
      compared++; if (cmd_ready !== 1'b1) begin mismatched++; $display("FAIL full_accept%0d: cmd_ready=%b required 1", i, cmd_ready); end
    end
    @(negedge clk);
    cmd_op = 3'd5; cmd_a = 8'd9; cmd_b = 8'd1;
    compared++; if (cmd_ready !== 1'b0) begin mismatched++; $display("FAIL full_5th_ready: got %b required 0", cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    compared++; if (busy !== 1'b1 || q_data.size() !== 0) begin mismatched++; $display("FAIL full_held: busy=%b results=%0d required 1/0", busy, q_data.size()); end
    hold_off = 1'b0;
    wait_res(4);
    for (int i = 0; i < 4; i++) begin
      compared++; if (q_data[i] !== ex[i] || q_err[i] !== 1'b0) begin mismatched++; $display("FAIL full_order%0d: got d=%h e=%b required %h/0", i, q_data[i], q_err[i], ex[i]); end
    end
    repeat (20) @(negedge clk);
    compared++; if (q_data.size() !== 4) begin mismatched++; $display("FAIL full_5th_dropped: got %0d results required 4", q_data.size()); end
  endtask

  task automatic test_reset_mid();
    int n0;
    clear_mon();
    no_run = 1'b1;
    push(3'd4, 8'd2, 8'd3, 2'd0);
    push(3'd4, 8'd4, 8'd4, 2'd0);
    push(3'd4, 8'd5, 8'd5, 2'd0);
    repeat (2) @(negedge clk);
    n0 = q_data.size();
    rst = 1'b0;
    #1;
    compared++; if (alu_on !== 1'b0 || alu_in_sel !== 3'b100) begin mismatched++; $display("FAIL mid_rst_alu: on=%b in_sel=%b required 0/100", alu_on, alu_in_sel); end
    compared++; if (busy !== 1'b0 || cmd_ready !== 1'b0) begin mismatched++; $display("FAIL mid_rst_busy: busy=%b ready=%b required 0/0", busy, cmd_ready); end
    compared++; if ({alu_num1, alu_out_sel, res_valid, res_data} !== 24'h0) begin mismatched++; $display("FAIL mid_rst_regs: num1=%h out_sel=%b v=%b d=%h required 0", alu_num1, alu_out_sel, res_valid, res_data); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    compared++; if (q_data.size() !== n0 || busy !== 1'b0) begin mismatched++; $display("FAIL mid_rst_discard: results=%0d busy=%b required %0d/0", q_data.size(), busy, n0); end
    no_run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alu_error();
    test_timeout();
    test_illegal();
    test_fifo_full();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
